// File: rtl/ifu_fetch_queue_pkg.sv
// Shared defaults and queue-entry layout for the IFU fetch queue.
package ifu_fetch_queue_pkg;

    localparam int unsigned          IFQ_WIDTH    = 32;
    localparam logic [IFQ_WIDTH-1:0] IFQ_RESET_PC = 32'h8000_0000;
    localparam int unsigned          IFQ_DEPTH    = 4;

    // Queue entry is {pc, data, err}; pc sits in the MSBs.
    typedef struct packed {
        logic [IFQ_WIDTH-1:0] pc;
        logic [IFQ_WIDTH-1:0] data;
        logic                 err;
    } ifq_entry_t;

    function automatic int unsigned ifq_entry_w(input int unsigned width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// Instruction-memory request/response channel and decode-side instruction channel.
interface ifu_fetch_queue_if
    import ifu_fetch_queue_pkg::*;
#(
    parameter int unsigned WIDTH = IFQ_WIDTH
);

    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [WIDTH-1:0] imem_rsp_data;
    logic             imem_rsp_err;
    logic             inst_valid;
    logic             inst_ready;
    logic [WIDTH-1:0] inst_pc;
    logic [WIDTH-1:0] inst_data;
    logic             inst_err;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, inst_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, inst_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready
    );

endinterface

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with flush; flush beats push/pop, and push at full is taken only alongside a pop.
module ifu_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Sequential instruction fetch with credit-limited requests, in-order responses,
// a DEPTH-entry instruction queue and redirect flush with stale-response dropping.
module ifu_fetch_queue
    import ifu_fetch_queue_pkg::*;
#(
    parameter int unsigned      WIDTH    = IFQ_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = IFQ_RESET_PC,
    parameter int unsigned      DEPTH    = IFQ_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [WIDTH-1:0]  redirect_pc,
    output logic [WIDTH-1:0]  pc_count,
    ifu_fetch_queue_if.master bus
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned CPW = CW + 1;
    localparam int unsigned EW  = ifq_entry_w(WIDTH);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic             req_valid_q, req_valid_d;
    logic [WIDTH-1:0] req_addr_q, req_addr_d;
    logic             req_stale_q, req_stale_d;
    logic [CW-1:0]    outs_q, outs_d;
    logic [CW-1:0]    drop_q, drop_d;

    logic             fire, held, rsp_valid, rsp_ok, rsp_drop, push, pop, credit_ok;
    logic [CW-1:0]    fifo_count, count_d;
    logic             fifo_full, fifo_empty;
    logic [EW-1:0]    fifo_wdata, fifo_rdata;
    logic [WIDTH-1:0] redirect_tgt;
    logic             unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign rsp_valid            = bus.imem_rsp_valid;

    always_comb begin
        fire      = req_valid_q && bus.imem_req_ready;
        held      = req_valid_q && !bus.imem_req_ready;
        rsp_ok    = rsp_valid && (outs_q != '0);
        rsp_drop  = rsp_ok && (redirect_valid || (drop_q != '0));
        push      = rsp_ok && !rsp_drop;
        pop       = bus.inst_ready && !fifo_empty;
        outs_d    = outs_q + CW'(fire) - CW'(rsp_ok);
        count_d   = redirect_valid ? '0 : fifo_count + CW'(push) - CW'(pop);
        credit_ok = ({1'b0, outs_d} + {1'b0, count_d} + CPW'(1)) <= CPW'(DEPTH);

        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        // Kept responses are always consecutive from the last redirect target,
        // so their PC comes from a counter rather than an address FIFO.
        if (redirect_valid) begin
            drop_d     = outs_d + CW'(held);
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
        end else begin
            if (rsp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
            if (fire && !req_stale_q)     fetch_pc_d = fetch_pc_q + WIDTH'(4);
            if (push)                     rsp_pc_d = rsp_pc_q + WIDTH'(4);
        end

        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_stale_d = req_stale_q;
        // A pending request stays stable; if a redirect overtakes it, it is marked
        // stale so its acceptance does not advance fetch_pc.
        if (held) begin
            if (redirect_valid) req_stale_d = 1'b1;
        end else begin
            req_valid_d = credit_ok;
            req_stale_d = 1'b0;
            if (credit_ok) req_addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_stale_q <= 1'b0;
            outs_q      <= '0;
            drop_q      <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_stale_q <= req_stale_d;
            outs_q      <= outs_d;
            drop_q      <= drop_d;
        end
    end

    assign fifo_wdata = {rsp_pc_q, bus.imem_rsp_data, bus.imem_rsp_err};

    ifu_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = req_addr_q;
    assign bus.inst_valid     = !fifo_empty;
    assign {bus.inst_pc, bus.inst_data, bus.inst_err} = fifo_rdata;
    assign pc_count           = fetch_pc_q;

    a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_valid |-> (outs_q != '0))
        else $error("ifu_fetch_queue: response with no request outstanding");

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (!fifo_full || pop))
        else $error("ifu_fetch_queue: push into full queue");

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with an in-order instruction-memory model.
module tb_ifu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc_count;

    ifu_fetch_queue_if #(.WIDTH(32)) bus ();

    ifu_fetch_queue #(
        .WIDTH    (32),
        .RESET_PC (32'h8000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc_count       (pc_count),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          n_acc;
    logic [31:0] inflight [$];
    bit          mem_auto;
    bit          err_en;
    logic [31:0] err_addr;

    logic [31:0] wrap_pc  [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    logic [31:0] wrap_err [4] = '{32'd0, 32'd1, 32'd0, 32'd0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: answers in order, one cycle after acceptance, while mem_auto is set.
    task automatic tick();
        bit          acc;
        bit          rsp;
        logic [31:0] a;
        acc = bus.imem_req_valid && bus.imem_req_ready && rst_n;
        rsp = bus.imem_rsp_valid && rst_n;
        a   = bus.imem_req_addr;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            inflight.delete();
        end else begin
            if (rsp) void'(inflight.pop_front());
            if (acc) begin
                inflight.push_back(a);
                n_acc++;
            end
        end
        if (rst_n && mem_auto && inflight.size() != 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = inflight[0] ^ 32'hFFFF_0000;
            bus.imem_rsp_err   = err_en && (inflight[0] == err_addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
            bus.imem_rsp_err   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        bus.inst_ready     = 1'b0;
        bus.imem_req_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_inst(input string tag);
        for (int i = 0; i < 20 && !bus.inst_valid; i++) tick();
        check(tag, bus.inst_valid, 1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_acc    = 0;
        mem_auto = 1'b1;
        err_en   = 1'b0;
        err_addr = '0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;

        // Reset state and free-running fetch
        do_reset();
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_pc_count", pc_count, 32'h8000_0000);
        check("rst_inst_pc", bus.inst_pc, 0);
        check("rst_inst_data", bus.inst_data, 0);
        check("rst_inst_err", bus.inst_err, 0);
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        tick();
        check("a_req_valid", bus.imem_req_valid, 1);
        check("a_req_addr", bus.imem_req_addr, 32'h8000_0000);
        check("a_inst_valid", bus.inst_valid, 0);
        tick();
        check("b_inst_valid", bus.inst_valid, 0);
        check("b_req_addr", bus.imem_req_addr, 32'h8000_0004);
        check("b_pc_count", pc_count, 32'h8000_0004);
        tick();
        check("c_inst_valid", bus.inst_valid, 1);
        check("c_inst_data", bus.inst_data, 32'h7FFF_0000);
        for (int k = 0; k < 6; k++) begin
            check("run_valid", bus.inst_valid, 1);
            check("run_pc", bus.inst_pc, 32'h8000_0000 + 32'(4 * k));
            tick();
        end

        // Decode stall: credit limits outstanding + queued to DEPTH
        do_reset();
        bus.imem_req_ready = 1'b1;
        n_acc = 0;
        repeat (12) tick();
        check("stall_acc", n_acc, 4);
        check("stall_req_valid", bus.imem_req_valid, 0);
        check("stall_head", bus.inst_pc, 32'h8000_0000);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        check("pop_req_valid", bus.imem_req_valid, 1);
        check("pop_req_addr", bus.imem_req_addr, 32'h8000_0010);
        check("pop_head", bus.inst_pc, 32'h8000_0004);
        tick();
        check("pop_req_valid2", bus.imem_req_valid, 0);
        repeat (3) tick();
        check("pop_acc", n_acc, 5);
        bus.inst_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            check("drain_valid", bus.inst_valid, 1);
            check("drain_pc", bus.inst_pc, 32'h8000_0000 + 32'(4 * k));
            tick();
        end

        // Redirect with two responses in flight and one request pending
        do_reset();
        mem_auto           = 1'b0;
        bus.inst_ready     = 1'b1;
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        check("rd_pc_count", pc_count, 32'h8000_0100);
        check("rd_req_valid", bus.imem_req_valid, 1);
        check("rd_req_addr", bus.imem_req_addr, 32'h8000_0008);
        check("rd_drop", 32'(dut.drop_q), 3);
        mem_auto           = 1'b1;
        bus.imem_req_ready = 1'b1;
        wait_inst("rd_wait");
        check("rd_first_pc", bus.inst_pc, 32'h8000_0100);
        tick();
        check("rd_second_pc", bus.inst_pc, 32'h8000_0104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        tick();
        redirect_valid = 1'b0;
        check("rd_unaligned_pc_count", pc_count, 32'h8000_0100);
        check("rd_unaligned_flush", bus.inst_valid, 0);
        wait_inst("rd_unaligned_wait");
        check("rd_unaligned_pc", bus.inst_pc, 32'h8000_0100);

        // Redirect coinciding with a response and a pop
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        repeat (6) tick();
        check("same_pre_rsp", bus.imem_rsp_valid, 1);
        check("same_pre_inst", bus.inst_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        check("same_empty", bus.inst_valid, 0);
        check("same_drop", 32'(dut.drop_q), 1);
        wait_inst("same_wait");
        check("same_drop_zero", 32'(dut.drop_q), 0);
        check("same_first_pc", bus.inst_pc, 32'h8000_0200);

        // Error response and address wrap
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        err_en   = 1'b1;
        err_addr = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        wait_inst("wrap_wait");
        for (int k = 0; k < 4; k++) begin
            check("wrap_valid", bus.inst_valid, 1);
            check("wrap_pc", bus.inst_pc, wrap_pc[k]);
            check("wrap_err", bus.inst_err, wrap_err[k]);
            if (k == 1) check("wrap_data", bus.inst_data, 32'h0000_FFFC);
            tick();
        end
        err_en = 1'b0;

        // Reset mid-stream with three entries queued
        do_reset();
        bus.imem_req_ready = 1'b1;
        repeat (5) tick();
        check("mid_count", 32'(dut.u_fifo.count_q), 3);
        rst_n = 1'b0;
        tick();
        check("mid_inst_valid", bus.inst_valid, 0);
        check("mid_pc_count", pc_count, 32'h8000_0000);
        check("mid_req_valid", bus.imem_req_valid, 0);
        rst_n          = 1'b1;
        bus.inst_ready = 1'b1;
        wait_inst("mid_wait");
        check("mid_first_pc", bus.inst_pc, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
